// File: rtl/match_sequencer.sv
// Ping-pong match sequencer: serve/rally/pause/over FSM,
// score registers and server selection.
module match_sequencer #(
    parameter int WIN_SCORE = 5,
    parameter int PAUSE_MS  = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_1ms,
    input  logic       serve_btn,
    input  logic       goal_p1,
    input  logic       goal_p2,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic [1:0] gstate,
    output logic       ball_hold,
    output logic       ball_launch,
    output logic       server
);
    typedef enum logic [2:0] {
        IDLE,
        SERVE,
        RALLY,
        PAUSE,
        OVER
    } state_t;

    localparam logic [3:0]  WIN = WIN_SCORE[3:0];
    localparam logic [11:0] PMS = PAUSE_MS[11:0];

    state_t      state;
    logic        ms_s1;
    logic        ms_s2;
    logic        ms_prev;
    logic        serve_prev;
    logic [11:0] pause_cnt;
    logic        ms_tick;
    logic        serve_edge;
    logic [3:0]  p1_next;
    logic [3:0]  p2_next;
    logic [11:0] cnt_next;

    assign ms_tick    = ms_s2 & ~ms_prev;
    assign serve_edge = serve_btn & ~serve_prev;
    assign p1_next    = p1_score + 4'd1;
    assign p2_next    = p2_score + 4'd1;
    assign cnt_next   = pause_cnt + 12'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            ms_s1       <= 1'b0;
            ms_s2       <= 1'b0;
            ms_prev     <= 1'b0;
            serve_prev  <= 1'b0;
            pause_cnt   <= 12'd0;
            p1_score    <= 4'd0;
            p2_score    <= 4'd0;
            gstate      <= 2'b00;
            ball_hold   <= 1'b1;
            ball_launch <= 1'b0;
            server      <= 1'b0;
        end else begin
            ms_s1       <= clk_1ms;
            ms_s2       <= ms_s1;
            ms_prev     <= ms_s2;
            serve_prev  <= serve_btn;
            ball_launch <= 1'b0;
            unique case (state)
                IDLE, SERVE: begin
                    if (serve_edge) begin
                        state       <= RALLY;
                        gstate      <= 2'b01;
                        ball_hold   <= 1'b0;
                        ball_launch <= 1'b1;
                    end
                end
                RALLY: begin
                    // Simultaneous goals void the point
                    if (goal_p1 && goal_p2) begin
                        state     <= PAUSE;
                        ball_hold <= 1'b1;
                        pause_cnt <= 12'd0;
                    end else if (goal_p1) begin
                        p1_score  <= p1_next;
                        server    <= 1'b1;
                        ball_hold <= 1'b1;
                        pause_cnt <= 12'd0;
                        if (p1_next == WIN) begin
                            state  <= OVER;
                            gstate <= 2'b10;
                        end else begin
                            state <= PAUSE;
                        end
                    end else if (goal_p2) begin
                        p2_score  <= p2_next;
                        server    <= 1'b0;
                        ball_hold <= 1'b1;
                        pause_cnt <= 12'd0;
                        if (p2_next == WIN) begin
                            state  <= OVER;
                            gstate <= 2'b11;
                        end else begin
                            state <= PAUSE;
                        end
                    end
                end
                PAUSE: begin
                    if (ms_tick) begin
                        pause_cnt <= cnt_next;
                        if (cnt_next == PMS) begin
                            state <= SERVE;
                        end
                    end
                end
                OVER: begin
                    if (serve_edge) begin
                        state    <= IDLE;
                        gstate   <= 2'b00;
                        p1_score <= 4'd0;
                        p2_score <= 4'd0;
                        server   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_match_sequencer.sv
// Directed bench for match_sequencer with WIN_SCORE=5, PAUSE_MS=3.
module tb_match_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clk_1ms = 1'b0;
    logic       serve_btn = 1'b0;
    logic       goal_p1 = 1'b0;
    logic       goal_p2 = 1'b0;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic [1:0] gstate;
    logic       ball_hold;
    logic       ball_launch;
    logic       server;

    int n_cmp = 0;
    int n_bad = 0;

    match_sequencer #(
        .WIN_SCORE(5),
        .PAUSE_MS (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_1ms    (clk_1ms),
        .serve_btn  (serve_btn),
        .goal_p1    (goal_p1),
        .goal_p2    (goal_p2),
        .p1_score   (p1_score),
        .p2_score   (p2_score),
        .gstate     (gstate),
        .ball_hold  (ball_hold),
        .ball_launch(ball_launch),
        .server     (server)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ms_tick();
        clk_1ms = 1'b1;
        cyc(4);
        clk_1ms = 1'b0;
        cyc(4);
    endtask

    task automatic press(output logic launched);
        serve_btn = 1'b1;
        cyc(1);
        launched = ball_launch;
        serve_btn = 1'b0;
        cyc(1);
    endtask

    task automatic goal(input int who);
        goal_p1 = (who == 1);
        goal_p2 = (who == 2);
        cyc(1);
        goal_p1 = 1'b0;
        goal_p2 = 1'b0;
    endtask

    task automatic pause_then_serve();
        logic l;
        repeat (3) ms_tick();
        press(l);
        check("reserve_launch", int'(l), 1);
    endtask

    task automatic outs(input string tag, input int p1, input int p2,
                        input int gs, input int hold, input int srv);
        check({tag, "_p1"}, int'(p1_score), p1);
        check({tag, "_p2"}, int'(p2_score), p2);
        check({tag, "_gstate"}, int'(gstate), gs);
        check({tag, "_hold"}, int'(ball_hold), hold);
        check({tag, "_server"}, int'(server), srv);
    endtask

    initial begin
        logic l;
        int   launches;
        int   seq [5] = '{2, 2, 1, 2, 1};

        cyc(2);
        outs("reset", 0, 0, 0, 1, 0);
        check("reset_launch", int'(ball_launch), 0);
        reset = 1'b1;
        cyc(2);

        // first serve from IDLE
        serve_btn = 1'b1;
        cyc(1);
        check("srv1_launch", int'(ball_launch), 1);
        outs("srv1", 0, 0, 1, 0, 0);
        cyc(1);
        check("srv1_launch_end", int'(ball_launch), 0);
        serve_btn = 1'b0;
        cyc(1);

        // P2 goal, pause of 3 ticks
        goal(2);
        outs("g2", 0, 1, 1, 1, 0);
        press(l);
        check("pause_press0", int'(l), 0);
        ms_tick();
        ms_tick();
        press(l);
        check("pause_press2", int'(l), 0);
        ms_tick();
        check("serve_hold", int'(ball_hold), 1);

        // held button in SERVE gives a single launch
        launches = 0;
        serve_btn = 1'b1;
        for (int i = 0; i < 50; i++) begin
            cyc(1);
            if (ball_launch) launches++;
        end
        serve_btn = 1'b0;
        cyc(1);
        check("held_launches", launches, 1);
        check("held_hold", int'(ball_hold), 0);

        // P1 runs to 5
        for (int i = 0; i < 5; i++) begin
            goal(1);
            check("p1_run", int'(p1_score), i + 1);
            if (i < 4) begin
                check("p1_run_srv", int'(server), 1);
                pause_then_serve();
            end
        end
        outs("p1_win", 5, 1, 2, 1, 1);
        goal(1);
        check("frozen_p1", int'(p1_score), 5);
        check("frozen_gs", int'(gstate), 2);
        press(l);
        check("over_launch", int'(l), 0);
        outs("restart", 0, 0, 0, 1, 0);

        // void point at 2-3
        press(l);
        check("v_launch", int'(l), 1);
        foreach (seq[i]) begin
            goal(seq[i]);
            pause_then_serve();
        end
        outs("pre_void", 2, 3, 1, 0, 1);
        goal_p1 = 1'b1;
        goal_p2 = 1'b1;
        cyc(1);
        goal_p1 = 1'b0;
        goal_p2 = 1'b0;
        outs("void", 2, 3, 1, 1, 1);
        press(l);
        check("void_pause", int'(l), 0);

        // async reset mid-pause at 4-1
        reset = 1'b0;
        cyc(1);
        reset = 1'b1;
        cyc(1);
        press(l);
        check("r2_launch", int'(l), 1);
        for (int i = 0; i < 4; i++) begin
            goal(i == 3 ? 2 : 1);
            pause_then_serve();
        end
        goal(1);
        outs("pre_rst", 4, 1, 1, 1, 1);
        ms_tick();
        #3;
        reset = 1'b0;
        #1;
        outs("async_rst", 0, 0, 0, 1, 0);
        check("async_launch", int'(ball_launch), 0);
        cyc(1);
        reset = 1'b1;
        cyc(2);
        serve_btn = 1'b1;
        cyc(1);
        check("post_rst_launch", int'(ball_launch), 1);
        outs("post_rst", 0, 0, 1, 0, 0);
        serve_btn = 1'b0;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/match_sequencer.md
# match_sequencer

Top-level rally controller for the ping-pong game. It sequences each match (idle, serve, rally, post-point pause, game over), owns both player score registers, and decides who serves next. It drives the ball engine's hold/launch controls and publishes the 2-bit game state used by the display and sound blocks. It sits between the ball/paddle datapath, which reports goals, and the score display.

## Interface
- WIN_SCORE, 5: goals needed to win; legal range 1..15.
- PAUSE_MS, 1000: post-point pause length in clk_1ms ticks; legal range 1..4095.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset; clears every register immediately.
- clk_1ms  in  1  slow 1 ms clock.
  - Treated as a data input.
  - Double-flop synchronised into clk; each rising edge is one ms tick.
- serve_btn  in  1  debounced, clk-synchronous serve button.
  - Internally rising-edge detected; a held button produces one event.
- goal_p1  in  1  ball crossed P2's goal line (point to P1); sampled every clk.
- goal_p2  in  1  ball crossed P1's goal line (point to P2); sampled every clk.
- p1_score  out  4  P1 score, registered.
- p2_score  out  4  P2 score, registered.
- gstate  out  2  match state.
  - 00 begin; 01 playing (serve, rally or pause); 10 P1 won; 11 P2 won.
- ball_hold  out  1  1 = ball parked at server's paddle; 0 = ball free.
- ball_launch  out  1  single-cycle pulse that releases the ball.
- server  out  1  serving player: 0 = P1, 1 = P2.

## Operation
FSM states: IDLE, SERVE, RALLY, PAUSE, OVER. All outputs are registered.

Reset values: state IDLE, p1_score 0, p2_score 0, gstate 00, ball_hold 1, ball_launch 0, server 0, pause counter 0. Both edge-detect history flops are cleared.

- IDLE: gstate 00, ball_hold 1.
  - A serve_btn edge moves to RALLY with ball_launch = 1 for one cycle.
- SERVE: gstate 01, ball_hold 1.
  - A serve_btn edge moves to RALLY with ball_launch = 1 for one cycle.
- RALLY: gstate 01, ball_hold 0.
  - goal_p1 alone: p1_score + 1, server ← 1 (the conceding player serves). If the new score equals WIN_SCORE go to OVER, otherwise go to PAUSE.
  - goal_p2 alone: symmetric, with server ← 0.
  - goal_p1 and goal_p2 in the same cycle: void point. No score change, server unchanged, go to PAUSE.
- PAUSE: gstate 01, ball_hold 1.
  - Counter cleared on entry; it increments once per ms tick.
  - On the tick that brings the count to PAUSE_MS, go to SERVE.
- OVER: gstate 10 if p1_score == WIN_SCORE, else 11; ball_hold 1; scores frozen.
  - A serve_btn edge goes to IDLE, clears both scores and sets server ← 0.

Ignored inputs:
- Goal inputs are ignored outside RALLY.
- serve_btn edges are ignored in RALLY and PAUSE and are not queued.
- Ms ticks are ignored outside PAUSE.

Arithmetic: scores are 4-bit unsigned. An increment can only occur below WIN_SCORE, so scores never exceed WIN_SCORE and never wrap.

Reset mid-operation (any state): all registers return to their reset values asynchronously. An in-flight ball_launch pulse is cut off.

## Timing
- Goal sampled high at clk edge N:
  - Score, server and new state are visible after edge N.
  - gstate 10/11 is visible after edge N when the goal is the winning one.
- serve_btn rises before edge N (previous sample 0): state RALLY, ball_launch = 1 and ball_hold = 0 are visible after edge N. ball_launch returns to 0 after edge N+1.
- ms tick latency:
  - clk_1ms rising edge to detected tick: 2–3 clk cycles (two sync flops plus edge detect).
  - PAUSE lasts PAUSE_MS ticks, ±1 clk of sync jitter.
- A goal and a serve_btn edge in the same cycle in RALLY: the goal wins and the serve edge is dropped.

## Test plan
- Reset then a serve_btn edge → ball_launch is a single-cycle 1, gstate 01, ball_hold 0, server 0.
- In RALLY, pulse goal_p2 for 1 cycle → p2_score 1, server 0, PAUSE. With PAUSE_MS=3, SERVE is entered after the 3rd ms tick. A serve edge during the pause causes no launch.
- WIN_SCORE=5: P1 scores 5 goals with serves in between → gstate 10 after the 5th goal. Further goal_p1 pulses leave p1_score at 5. A serve edge returns to gstate 00 with both scores 0.
- goal_p1 and goal_p2 high in the same cycle during RALLY, with scores 2–3 → scores unchanged, server unchanged, state PAUSE.
- Assert reset low asynchronously mid-PAUSE, with scores 4–1 → all outputs are at reset values before the next clk edge. After release, a serve edge starts a new rally at 0–0.
- serve_btn held high for 50 cycles in SERVE → exactly one ball_launch pulse.
